// File: rtl/ram_port_arbiter_if.sv
// Cache-side request bus and shared RAM port of ram_port_arbiter.
// The arbiter uses the slave modport; caches and the RAM model sit on the master side.
interface ram_port_arbiter_if #(
    parameter int NUM_REQ       = 2,
    parameter int ADDRESS_WIDTH = 16
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address;
    logic [NUM_REQ-1:0]               req_rd;
    logic [NUM_REQ-1:0]               req_wr;
    logic [NUM_REQ*32-1:0]            req_data_wr;
    logic [31:0]                      req_data_rd;
    logic [NUM_REQ-1:0]               req_data_valid;
    logic [ADDRESS_WIDTH-1:0]         ram_address;
    logic                             ram_rd;
    logic                             ram_wr;
    logic [31:0]                      ram_data_wr;
    logic [31:0]                      ram_data_rd;
    logic                             ram_data_valid;
    logic                             busy;
    logic [ID_WIDTH-1:0]              owner;

    modport slave (
        input  req_address, req_rd, req_wr, req_data_wr, ram_data_rd, ram_data_valid,
        output req_data_rd, req_data_valid, ram_address, ram_rd, ram_wr, ram_data_wr,
               busy, owner
    );

    modport master (
        output req_address, req_rd, req_wr, req_data_wr, ram_data_rd, ram_data_valid,
        input  req_data_rd, req_data_valid, ram_address, ram_rd, ram_wr, ram_data_wr,
               busy, owner
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one word-RAM port among NUM_REQ cache controllers.
// Optional per-requester grant/wait counters are enabled by defining RAM_ARB_PERF_EN.
module ram_port_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_port_arbiter_if.slave     bus
`ifdef RAM_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0] perf_grants,
    output logic [NUM_REQ*16-1:0] perf_wait
`endif
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_r, state_next;
    logic [ID_WIDTH-1:0] owner_r, owner_next;
    logic [ID_WIDTH-1:0] last_r, last_next;
    logic [ID_WIDTH-1:0] winner;
    logic [ID_WIDTH-1:0] scan_idx;
    logic                found;
    logic [NUM_REQ-1:0]  req;
    logic                any_req;

    logic [ADDRESS_WIDTH-1:0] addr_slice [NUM_REQ];
    logic [31:0]              data_slice [NUM_REQ];

    assign req     = bus.req_rd | bus.req_wr;
    assign any_req = |req;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign addr_slice[i] = bus.req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign data_slice[i] = bus.req_data_wr[i*32 +: 32];
    end

    // Round-robin pick: first set request after the last winner, wrapping around.
    always_comb begin
        winner   = '0;
        scan_idx = '0;
        found    = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_WIDTH'((int'(last_r) + k) % NUM_REQ);
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            owner_r <= '0;
            last_r  <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            state_r <= state_next;
            owner_r <= owner_next;
            last_r  <= last_next;
        end
    end

    // The RAM port is a pure mux of the owner's slice, so its outputs drop with the owner's request.
    always_comb begin
        state_next         = state_r;
        owner_next         = owner_r;
        last_next          = last_r;
        bus.ram_address    = '0;
        bus.ram_rd         = 1'b0;
        bus.ram_wr         = 1'b0;
        bus.ram_data_wr    = '0;
        bus.req_data_valid = '0;
        case (state_r)
            IDLE: begin
                if (any_req) begin
                    state_next = BUSY;
                    owner_next = winner;
                    last_next  = winner;
                end
            end
            BUSY: begin
                bus.ram_address             = addr_slice[owner_r];
                bus.ram_rd                  = bus.req_rd[owner_r];
                bus.ram_wr                  = bus.req_wr[owner_r];
                bus.ram_data_wr             = data_slice[owner_r];
                bus.req_data_valid[owner_r] = bus.ram_data_valid;
                if (!req[owner_r]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_data_rd = bus.ram_data_rd;
    assign bus.busy        = (state_r == BUSY);
    assign bus.owner       = owner_r;

`ifdef RAM_ARB_PERF_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
        logic [15:0] grants_r;
        logic [15:0] wait_r;
        logic        granted;
        logic        waiting;

        assign granted = (state_r == IDLE) && any_req && (winner == ID_WIDTH'(i));
        assign waiting = req[i] && ((state_r == BUSY) ? (owner_r != ID_WIDTH'(i))
                                                       : (winner != ID_WIDTH'(i)));

        // Saturating counters so long runs never wrap back to small values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                grants_r <= '0;
                wait_r   <= '0;
            end else begin
                if (granted && grants_r != 16'hFFFF) begin
                    grants_r <= grants_r + 16'd1;
                end
                if (waiting && wait_r != 16'hFFFF) begin
                    wait_r <= wait_r + 16'd1;
                end
            end
        end

        assign perf_grants[i*16 +: 16] = grants_r;
        assign perf_wait[i*16 +: 16]   = wait_r;
    end
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: vector table, directed corner sequences
// and randomized traffic against a transaction-level model (perf checks with RAM_ARB_PERF_EN).
module tb_ram_port_arbiter;
    localparam int NUM_REQ = 2;
    localparam int AW      = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDRESS_WIDTH(AW)) bus ();

`ifdef RAM_ARB_PERF_EN
    logic [NUM_REQ*16-1:0] perf_grants;
    logic [NUM_REQ*16-1:0] perf_wait;
`endif

    ram_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef RAM_ARB_PERF_EN
        ,
        .perf_grants(perf_grants),
        .perf_wait(perf_wait)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [1:0]  cur_rd;
    logic [1:0]  cur_wr;
    logic [15:0] cur_addr [2];
    logic [31:0] cur_dw [2];
    logic        cur_rdv;
    logic [31:0] cur_rdata;

    // Reference model: who holds the port, and who won last.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_grants [2];
    int m_wait [2];

    typedef struct {
        logic        pre_reset;
        logic [1:0]  rd;
        logic [15:0] a0;
        logic [15:0] a1;
        logic        rdv;
        logic        busy;
        logic        owner;
        logic        ram_rd;
        logic [15:0] addr;
        logic [1:0]  dv;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic driveBus();
        bus.req_rd         = cur_rd;
        bus.req_wr         = cur_wr;
        bus.req_address    = {cur_addr[1], cur_addr[0]};
        bus.req_data_wr    = {cur_dw[1], cur_dw[0]};
        bus.ram_data_valid = cur_rdv;
        bus.ram_data_rd    = cur_rdata;
    endtask

    task automatic clearInputs();
        cur_rd    = '0;
        cur_wr    = '0;
        cur_rdv   = 1'b0;
        cur_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            cur_addr[i] = '0;
            cur_dw[i]   = '0;
        end
    endtask

    task automatic modelReset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = NUM_REQ - 1;
        for (int i = 0; i < 2; i++) begin
            m_grants[i] = 0;
            m_wait[i]   = 0;
        end
    endtask

    task automatic checkModel();
        logic [1:0]  exp_dv;
        logic [15:0] exp_addr;
        logic [31:0] exp_dw;
        logic        exp_rd;
        logic        exp_wr;
        exp_dv   = '0;
        exp_addr = '0;
        exp_dw   = '0;
        exp_rd   = 1'b0;
        exp_wr   = 1'b0;
        if (m_busy) begin
            exp_addr = cur_addr[m_owner];
            exp_dw   = cur_dw[m_owner];
            exp_rd   = cur_rd[m_owner];
            exp_wr   = cur_wr[m_owner];
            if (cur_rdv) exp_dv[m_owner] = 1'b1;
        end
        checkOutput("model_busy", bus.busy, m_busy);
        checkOutput("model_owner", bus.owner, m_owner);
        checkOutput("model_ram_rd", bus.ram_rd, exp_rd);
        checkOutput("model_ram_wr", bus.ram_wr, exp_wr);
        checkOutput("model_ram_address", bus.ram_address, exp_addr);
        checkOutput("model_ram_data_wr", bus.ram_data_wr, exp_dw);
        checkOutput("model_req_data_valid", bus.req_data_valid, exp_dv);
        checkOutput("model_req_data_rd", bus.req_data_rd, cur_rdata);
    endtask

    // Advance the model by one clock edge using the inputs presented this cycle.
    task automatic modelStep();
        logic [1:0] req;
        int         w;
        req = cur_rd | cur_wr;
        if (!m_busy) begin
            w = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (w < 0 && req[(m_last + k) % NUM_REQ]) w = (m_last + k) % NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && i != w) m_wait[i]++;
            end
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
                m_last  = w;
                m_grants[w]++;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && i != m_owner) m_wait[i]++;
            end
            if (!req[m_owner]) m_busy = 1'b0;
        end
    endtask

    // Starts and ends on a falling edge; inputs are held until the next call.
    task automatic applyStimulus();
        driveBus();
        #1;
        checkModel();
        modelStep();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearInputs();
        driveBus();
        #1;
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_owner", bus.owner, 0);
        checkOutput("reset_ram_rd", bus.ram_rd, 0);
        checkOutput("reset_ram_wr", bus.ram_wr, 0);
        checkOutput("reset_ram_address", bus.ram_address, 0);
        checkOutput("reset_ram_data_wr", bus.ram_data_wr, 0);
        checkOutput("reset_data_valid", bus.req_data_valid, 0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef RAM_ARB_PERF_EN
    task automatic checkPerf(input string tag);
        for (int i = 0; i < NUM_REQ; i++) begin
            checkOutput($sformatf("%s_grants%0d", tag, i), perf_grants[i*16 +: 16], m_grants[i]);
            checkOutput($sformatf("%s_wait%0d", tag, i), perf_wait[i*16 +: 16], m_wait[i]);
        end
    endtask
`endif

    initial begin
        int exp_seq [6];
        int bursts;
        int cnt;
        int left [2];
        exp_seq = '{0, 1, 0, 1, 0, 1};

        rst = 1'b1;
        clearInputs();
        driveBus();
        modelReset();
        @(negedge clk);

        // Single-requester burst, then simultaneous requests with release handoff.
        //               rst  rd     a0        a1        rdv  busy own rrd addr      dv
        vecs.push_back('{1'b1, 2'b01, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00});
        vecs.push_back('{1'b0, 2'b01, 16'h0040, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 2'b01});
        vecs.push_back('{1'b0, 2'b01, 16'h0044, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0044, 2'b01});
        vecs.push_back('{1'b0, 2'b01, 16'h0048, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0048, 2'b01});
        vecs.push_back('{1'b0, 2'b01, 16'h004C, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h004C, 2'b01});
        vecs.push_back('{1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00});
        vecs.push_back('{1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00});
        vecs.push_back('{1'b1, 2'b11, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00});
        vecs.push_back('{1'b0, 2'b11, 16'h0100, 16'h0200, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 2'b01});
        vecs.push_back('{1'b0, 2'b11, 16'h0104, 16'h0200, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0104, 2'b01});
        vecs.push_back('{1'b0, 2'b10, 16'h0000, 16'h0200, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b01});
        vecs.push_back('{1'b0, 2'b10, 16'h0000, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00});
        vecs.push_back('{1'b0, 2'b10, 16'h0000, 16'h0200, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0200, 2'b10});
        vecs.push_back('{1'b0, 2'b10, 16'h0000, 16'h0204, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0204, 2'b10});
        vecs.push_back('{1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
        vecs.push_back('{1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].pre_reset) doReset();
            cur_rd      = vecs[i].rd;
            cur_wr      = '0;
            cur_addr[0] = vecs[i].a0;
            cur_addr[1] = vecs[i].a1;
            cur_dw[0]   = $urandom;
            cur_dw[1]   = $urandom;
            cur_rdv     = vecs[i].rdv;
            cur_rdata   = $urandom;
            driveBus();
            #1;
            checkOutput($sformatf("vec%0d_busy", i), bus.busy, vecs[i].busy);
            checkOutput($sformatf("vec%0d_owner", i), bus.owner, vecs[i].owner);
            checkOutput($sformatf("vec%0d_ram_rd", i), bus.ram_rd, vecs[i].ram_rd);
            checkOutput($sformatf("vec%0d_ram_address", i), bus.ram_address, vecs[i].addr);
            checkOutput($sformatf("vec%0d_data_valid", i), bus.req_data_valid, vecs[i].dv);
            applyStimulus();
        end

        // Writeback then fetch by requester 1 while requester 0 waits.
        doReset();
        cur_wr      = 2'b10;
        cur_addr[1] = 16'h1230;
        cur_dw[1]   = $urandom;
        applyStimulus();
        cur_rd      = 2'b01;
        cur_addr[0] = 16'h0800;
        cur_rdv     = 1'b1;
        for (int w = 0; w < 4; w++) begin
            cur_addr[1] = 16'h1230 + 16'(4 * w);
            cur_dw[1]   = $urandom;
            cur_rdata   = $urandom;
            driveBus();
            #1;
            checkOutput("wb_owner", bus.owner, 1);
            checkOutput("wb_ram_wr", bus.ram_wr, 1);
            checkOutput("wb_ram_address", bus.ram_address, 16'h1230 + 16'(4 * w));
            applyStimulus();
        end
        cur_wr = 2'b00;
        cur_rd = 2'b11;
        for (int w = 0; w < 4; w++) begin
            cur_addr[1] = 16'h2000 + 16'(4 * w);
            cur_rdata   = $urandom;
            driveBus();
            #1;
            checkOutput("fetch_owner", bus.owner, 1);
            checkOutput("fetch_ram_rd", bus.ram_rd, 1);
            checkOutput("fetch_ram_wr", bus.ram_wr, 0);
            applyStimulus();
        end
        cur_rd  = 2'b01;
        cur_rdv = 1'b0;
        applyStimulus();
        driveBus();
        #1;
        checkOutput("handoff_idle_busy", bus.busy, 0);
        applyStimulus();
        driveBus();
        #1;
        checkOutput("handoff_owner", bus.owner, 0);
        checkOutput("handoff_ram_address", bus.ram_address, 16'h0800);
        applyStimulus();
        cur_rd = 2'b00;
        applyStimulus();
        applyStimulus();

        // Both requesters always back: strict alternation of 4-word bursts.
        doReset();
        bursts = 0;
        cnt    = 0;
        for (int cyc = 0; cyc < 200 && bursts < 6; cyc++) begin
            cur_rd    = 2'b11;
            cur_rdv   = 1'b0;
            cur_rdata = $urandom;
            if (m_busy) begin
                if (cnt < 4) begin
                    cur_rdv = 1'b1;
                    cnt++;
                end else begin
                    cur_rd[m_owner] = 1'b0;
                    cnt = 0;
                    bursts++;
                end
            end
            if (cnt == 1 && cur_rdv) begin
                driveBus();
                #1;
                checkOutput($sformatf("alt_owner%0d", bursts), bus.owner, exp_seq[bursts]);
            end
            applyStimulus();
        end
        checkOutput("alt_bursts", bursts, 6);
        cur_rd  = 2'b00;
        cur_rdv = 1'b0;
        applyStimulus();
`ifdef RAM_ARB_PERF_EN
        checkOutput("alt_perf_grants0", perf_grants[15:0], 3);
        checkOutput("alt_perf_grants1", perf_grants[31:16], 3);
        checkPerf("alt_perf");
`endif

        // Reset lands in the middle of requester 1's fetch.
        doReset();
        cur_rd      = 2'b10;
        cur_addr[0] = 16'h0500;
        cur_addr[1] = 16'h3000;
        applyStimulus();
        cur_rdv = 1'b1;
        for (int w = 0; w < 3; w++) begin
            cur_addr[1] = 16'h3000 + 16'(4 * w);
            cur_rdata   = $urandom;
            applyStimulus();
        end
        rst = 1'b1;
        #1;
        checkOutput("midrst_ram_rd", bus.ram_rd, 0);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_ram_address", bus.ram_address, 0);
        checkOutput("midrst_data_valid", bus.req_data_valid, 0);
        modelReset();
        @(negedge clk);
        rst     = 1'b0;
        cur_rd  = 2'b11;
        cur_rdv = 1'b0;
        applyStimulus();
        driveBus();
        #1;
        checkOutput("midrst_regrant_owner", bus.owner, 0);
        checkOutput("midrst_regrant_address", bus.ram_address, 16'h0500);
        applyStimulus();
        cur_rd = 2'b00;
        applyStimulus();
        applyStimulus();

        // Randomized traffic; bursts may be reads or writes and may give up while waiting.
        doReset();
        left = '{0, 0};
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (left[i] > 0) begin
                    left[i]--;
                    if (left[i] == 0) begin
                        cur_rd[i] = 1'b0;
                        cur_wr[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    left[i] = $urandom_range(1, 8);
                    if ($urandom_range(0, 1) == 1) cur_rd[i] = 1'b1;
                    else cur_wr[i] = 1'b1;
                end
                cur_addr[i] = 16'($urandom);
                cur_dw[i]   = $urandom;
            end
            cur_rdv   = 1'($urandom_range(0, 1));
            cur_rdata = $urandom;
            applyStimulus();
        end
        clearInputs();
        applyStimulus();
        applyStimulus();
`ifdef RAM_ARB_PERF_EN
        checkPerf("rand_perf");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one external word-RAM port between NUM_REQ cache controllers, e.g. an I-cache and a D-cache.
- Each requester sees the same RAM interface the caches already drive: address, rd, wr and write data out; read data and data-valid in.
- Grants are round-robin. A grant is held for a requester's whole miss sequence, covering both writeback and fetch, until that requester drops both rd and wr.
- Sits between the cache instances and the top-level RAM model or memory controller.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDRESS_WIDTH, 16, byte address width; matches the caches.
- ID_WIDTH, $clog2(NUM_REQ), width of the owner index; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_address  in  NUM_REQ*ADDRESS_WIDTH  per-requester address; requester i occupies slice [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- req_rd  in  NUM_REQ  per-requester read request
- req_wr  in  NUM_REQ  per-requester write request
- req_data_wr  in  NUM_REQ*32  per-requester write data
- req_data_rd  out  32  read data, broadcast to all requesters
- req_data_valid  out  NUM_REQ  data-valid, routed only to the owner
- ram_address  out  ADDRESS_WIDTH  to RAM
- ram_rd  out  1  to RAM
- ram_wr  out  1  to RAM
- ram_data_wr  out  32  to RAM
- ram_data_rd  in  32  from RAM
- ram_data_valid  in  1  from RAM; one pulse per word completed
- busy  out  1  a grant is active
- owner  out  ID_WIDTH  current or last granted requester

Behaviour:
- Request definition: req_i = req_rd[i] | req_wr[i].
- State machine has two states, IDLE and BUSY, held in registered state_r, owner_r and last_r.
- Reset: state_r=IDLE, owner_r=0, last_r=NUM_REQ-1, so requester 0 wins first.
  - busy=0, ram_rd=0, ram_wr=0, ram_address=0, ram_data_wr=0, req_data_valid=0, owner=0.
- IDLE:
  - All ram_* outputs are 0 and req_data_valid is 0.
  - If any req_i is set, the winner is the first set request scanning last_r+1, last_r+2, ... modulo NUM_REQ.
  - On that edge: owner_r<=winner, last_r<=winner, state_r<=BUSY.
- BUSY:
  - ram_address, ram_rd, ram_wr and ram_data_wr are a combinational mux of the owner_r slice. There is no added register stage, so address changes by the owner reach the RAM the same cycle.
  - req_data_valid[owner_r] = ram_data_valid; all other bits are 0.
  - req_data_rd = ram_data_rd at all times, in all states.
  - If req_owner=0, state_r<=IDLE on the next edge. The ram outputs already drop to 0 combinationally in that cycle because they follow the owner slice.
  - Non-owners are ignored and simply wait.
- Continuous hold: an owner switching ram_wr->ram_rd in one cycle (writeback->fetch) keeps the grant, because req_owner never drops.
- Arbitration latency: request in cycle 0 gives BUSY in cycle 1 with ram_rd/ram_wr visible in cycle 1. After a release, at least one IDLE cycle passes before the next grant.
- Fairness: once a release occurs, a continuously waiting requester is granted within NUM_REQ-1 grants.
- Simultaneous events:
  - All requests rise in the same cycle in IDLE: the round-robin winner takes it.
  - Owner releases while another requester is pending: IDLE for one cycle, then the pending requester is granted.
- ram_data_valid while IDLE is dropped and not forwarded.
- ram_data_valid in the owner's release cycle is still forwarded to the owner.
- req_rd and req_wr both high from one requester is illegal. It is passed through unchanged; the arbiter does not check it.
- Reset mid-burst: state returns to IDLE immediately and the ram outputs go to 0 asynchronously. Any burst in progress is abandoned; requesters are reset by the same rst.

Optional Feature:
- Macro: RAM_ARB_PERF_EN.
- Defined:
  - Adds output perf_grants (NUM_REQ*16), per-requester grant counts, each incremented on every IDLE->BUSY edge for that winner.
  - Adds output perf_wait (NUM_REQ*16), per-requester cycles with req_i=1 while not owner in BUSY, or not the winner in IDLE.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single requester 0: req_rd[0]=1, address 0x0040, RAM gives 4 valid pulses (address steps 0x0040, 0x0044, 0x0048, 0x004C) then rd drops.
  - Required: ram_address tracks each step in the same cycle, req_data_valid=2'b01 on each pulse, busy falls the cycle after rd drops.
- Requesters 0 and 1 raise rd in the same cycle from reset.
  - Required: owner=0 first, owner=1 after requester 0 releases with exactly one IDLE cycle between.
  - Requester 1 sees req_data_valid[1]=0 throughout requester 0's burst.
- Requester 1 does writeback (wr=1, 4 words to 0x1230..0x123C) then fetch (rd=1 the same cycle wr=0) while requester 0 is waiting.
  - Required: no grant change until requester 1's rd drops; ram_wr->ram_rd switch appears in a single cycle.
- Back-to-back alternation, both always requesting, 6 bursts.
  - Required: owner sequence 0,1,0,1,0,1.
- rst asserted mid-fetch while owner=1 at word 2.
  - Required: ram_rd=0 and busy=0 immediately; after release, requester 0 is granted first.
- RAM_ARB_PERF_EN defined, run the alternation scenario.
  - Required: perf_grants = 3 for each requester; perf_wait equals the measured wait cycles (for example, 5 per burst with 4-word bursts plus 1 idle cycle).
